rca_seq_ctrl: RTL and testbench

RCA_SEQ_CTRL -- requirements
Module: rca_seq_ctrl

---
 rtl/rca_seq_ctrl_if.sv | 41 ++++
 rtl/rca_seq_ctrl.sv | 124 ++++++++++++
 tb/tb_rca_seq_ctrl.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rca_seq_ctrl_if.sv
//------------------------------------------------------------------------------
// Module  : rca_seq_ctrl_if
// Brief   : Request/response handshake and external 4-bit slice port bundle.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

interface rca_seq_ctrl_if #(
   parameter int NIB = 4
);
   localparam int W = 4 * NIB;

   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  op_a;
   logic [W-1:0]  op_b;
   logic          op_cin;
   logic [3:0]    slc_a;
   logic [3:0]    slc_b;
   logic          slc_cin;
   logic [3:0]    slc_sum;
   logic          slc_cout;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  res_sum;
   logic          res_cout;
   logic          busy;

   modport slave (
      input  in_valid, op_a, op_b, op_cin, slc_sum, slc_cout, out_ready,
      output in_ready, slc_a, slc_b, slc_cin, out_valid, res_sum, res_cout, busy
   );

   modport master (
      output in_valid, op_a, op_b, op_cin, slc_sum, slc_cout, out_ready,
      input  in_ready, slc_a, slc_b, slc_cin, out_valid, res_sum, res_cout, busy
   );
endinterface

`default_nettype wire

// File: rtl/rca_seq_ctrl.sv
//------------------------------------------------------------------------------
// Module  : rca_seq_ctrl
// Brief   : Sequences a W-bit add through an external 4-bit adder slice.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module rca_seq_ctrl #(
   parameter int NIB = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   rca_seq_ctrl_if.slave  bus
);
   localparam int W    = 4 * NIB;
   localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
   localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NIB - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]      state_q, state_d;
   logic [IDXW-1:0] idx_q,   idx_d;
   logic            carry_q, carry_d;
   logic [W-1:0]    a_q,     a_d;
   logic [W-1:0]    b_q,     b_d;
   logic [W-1:0]    sum_q,   sum_d;
   logic            cout_q,  cout_d;

   logic [IDXW+1:0] bit_base;
   logic [3:0]      slc_a;
   logic [3:0]      slc_b;
   logic            slc_cin;

   assign bit_base = {idx_q, 2'b00};

   always_comb begin
      slc_a   = 4'h0;
      slc_b   = 4'h0;
      slc_cin = 1'b0;
      if (state_q == S_RUN) begin
         slc_a   = a_q[bit_base +: 4];
         slc_b   = b_q[bit_base +: 4];
         slc_cin = carry_q;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      carry_d = carry_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      case (state_q)
         S_IDLE: begin
            if (bus.in_valid) begin
               a_d     = bus.op_a;
               b_d     = bus.op_b;
               carry_d = bus.op_cin;
               idx_d   = '0;
               sum_d   = '0;
               cout_d  = 1'b0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            sum_d[bit_base +: 4] = bus.slc_sum;
            carry_d              = bus.slc_cout;
            if (idx_q == IDX_LAST) begin
               cout_d  = bus.slc_cout;
               idx_d   = '0;
               state_d = S_DONE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         S_DONE: begin
            // Result is held until the consumer takes it.
            if (bus.out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         carry_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
      end
   end

   assign bus.in_ready  = (state_q == S_IDLE);
   assign bus.busy      = (state_q != S_IDLE);
   assign bus.out_valid = (state_q == S_DONE);
   assign bus.slc_a     = slc_a;
   assign bus.slc_b     = slc_b;
   assign bus.slc_cin   = slc_cin;
   assign bus.res_sum   = sum_q;
   assign bus.res_cout  = cout_q;

endmodule

`default_nettype wire

// File: tb/tb_rca_seq_ctrl.sv
//------------------------------------------------------------------------------
// Module  : tb_rca_seq_ctrl
// Brief   : Self-checking bench for rca_seq_ctrl with an ideal slice adder.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_rca_seq_ctrl;
   localparam int NIB = 4;
   localparam int W   = 4 * NIB;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   rca_seq_ctrl_if #(.NIB(NIB)) bus ();

   rca_seq_ctrl #(.NIB(NIB)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Ideal external 4-bit adder slice.
   always_comb begin
      {bus.slc_cout, bus.slc_sum} = {1'b0, bus.slc_a} + {1'b0, bus.slc_b} + {4'h0, bus.slc_cin};
   end

   function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
      return {1'b0, a} + {1'b0, b} + (W+1)'(cin);
   endfunction

   // Carry entering slice i is the carry out of the low 4*i bits of the full sum.
   function automatic logic ref_slice_cin(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic cin, input int i);
      logic [W:0] m;
      logic [W:0] lo;
      m  = ((W+1)'(1) << (4 * i)) - (W+1)'(1);
      lo = ({1'b0, a} & m) + ({1'b0, b} & m) + (W+1)'(cin);
      return lo[4 * i];
   endfunction

   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input logic rdy, output logic [W-1:0] s, output logic c,
                        output int lat, output int acc_wait, output int acc_cyc,
                        output logic [7:0] cins);
      logic took;
      bus.op_a      = a;
      bus.op_b      = b;
      bus.op_cin    = cin;
      bus.in_valid  = 1'b1;
      bus.out_ready = rdy;
      acc_wait = 0;
      took     = 1'b0;
      while (!took && acc_wait < 20) begin
         took = bus.in_ready;
         @(posedge clk); #1;
         if (!took) acc_wait++;
      end
      acc_cyc      = cyc;
      bus.in_valid = 1'b0;
      bus.op_a     = W'($urandom);
      bus.op_b     = W'($urandom);
      bus.op_cin   = 1'($urandom_range(0, 1));
      lat  = 0;
      cins = '0;
      while (!bus.out_valid && lat < 20) begin
         if (lat < 8) cins[lat] = bus.slc_cin;
         @(posedge clk); #1;
         lat++;
      end
      s = bus.res_sum;
      c = bus.res_cout;
   endtask

   task automatic test_reset();
      #2;
      checks++;
      if ({bus.in_ready, bus.out_valid, bus.busy} !== 3'b100) begin
         errors++;
         $display("FAIL reset_flags got %b want 100", {bus.in_ready, bus.out_valid, bus.busy});
      end
      checks++;
      if ({bus.slc_a, bus.slc_b, bus.slc_cin} !== 9'h0) begin
         errors++;
         $display("FAIL reset_slice got %h want 000", {bus.slc_a, bus.slc_b, bus.slc_cin});
      end
      checks++;
      if ({bus.res_cout, bus.res_sum} !== 17'h0) begin
         errors++;
         $display("FAIL reset_result got %h want 00000", {bus.res_cout, bus.res_sum});
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task automatic test_vectors();
      logic [W-1:0] va [3] = '{16'h1234, 16'hFFFF, 16'hFFFF};
      logic [W-1:0] vb [3] = '{16'h0FFF, 16'h0001, 16'hFFFF};
      logic         vc [3] = '{1'b0, 1'b0, 1'b1};
      logic [W-1:0] s;
      logic         c;
      int           lat, aw, ac;
      logic [7:0]   cins;
      logic [W:0]   exp;
      for (int k = 0; k < 3; k++) begin
         exp = ref_add(va[k], vb[k], vc[k]);
         do_op(va[k], vb[k], vc[k], 1'b1, s, c, lat, aw, ac, cins);
         checks++;
         if (lat !== NIB) begin
            errors++;
            $display("FAIL vec%0d_latency got %0d want %0d", k, lat, NIB);
         end
         checks++;
         if ({c, s} !== exp) begin
            errors++;
            $display("FAIL vec%0d_result got %h want %h", k, {c, s}, exp);
         end
         for (int i = 0; i < NIB; i++) begin
            checks++;
            if (cins[i] !== ref_slice_cin(va[k], vb[k], vc[k], i)) begin
               errors++;
               $display("FAIL vec%0d_slc_cin%0d got %b want %b", k, i, cins[i],
                        ref_slice_cin(va[k], vb[k], vc[k], i));
            end
         end
         @(posedge clk); #1;
         checks++;
         if ({bus.in_ready, bus.out_valid, bus.busy} !== 3'b100) begin
            errors++;
            $display("FAIL vec%0d_return_idle got %b want 100", k, {bus.in_ready, bus.out_valid, bus.busy});
         end
      end
   endtask

   task automatic test_hold();
      logic [W-1:0] s;
      logic         c;
      int           lat, aw, ac;
      logic [7:0]   cins;
      logic [W:0]   exp;
      exp = ref_add(16'hA5C3, 16'h7E19, 1'b1);
      do_op(16'hA5C3, 16'h7E19, 1'b1, 1'b0, s, c, lat, aw, ac, cins);
      checks++;
      if ({c, s} !== exp) begin
         errors++;
         $display("FAIL hold_result got %h want %h", {c, s}, exp);
      end
      bus.in_valid = 1'b1;
      bus.op_a     = 16'h1111;
      bus.op_b     = 16'h2222;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         checks++;
         if ({bus.out_valid, bus.in_ready, bus.busy, bus.res_cout, bus.res_sum} !== {3'b101, exp}) begin
            errors++;
            $display("FAIL hold_cycle%0d got %h want %h", k,
                     {bus.out_valid, bus.in_ready, bus.busy, bus.res_cout, bus.res_sum}, {3'b101, exp});
         end
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      checks++;
      if ({bus.in_ready, bus.out_valid, bus.busy} !== 3'b100) begin
         errors++;
         $display("FAIL hold_release got %b want 100", {bus.in_ready, bus.out_valid, bus.busy});
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_abort();
      logic [W-1:0] s;
      logic         c;
      int           lat, aw, ac, seen;
      logic [7:0]   cins;
      bus.op_a      = 16'hF0F0;
      bus.op_b      = 16'h0F0F;
      bus.op_cin    = 1'b1;
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      checks++;
      if (bus.busy !== 1'b1) begin
         errors++;
         $display("FAIL abort_running got busy=%b want 1", bus.busy);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({bus.in_ready, bus.out_valid, bus.busy, bus.slc_a, bus.slc_b, bus.slc_cin} !== 12'h800) begin
         errors++;
         $display("FAIL abort_outputs got %h want 800",
                  {bus.in_ready, bus.out_valid, bus.busy, bus.slc_a, bus.slc_b, bus.slc_cin});
      end
      checks++;
      if ({bus.res_cout, bus.res_sum} !== 17'h0) begin
         errors++;
         $display("FAIL abort_result got %h want 00000", {bus.res_cout, bus.res_sum});
      end
      seen = 0;
      for (int k = 0; k < NIB + 2; k++) begin
         @(posedge clk); #1;
         if (bus.out_valid) seen++;
      end
      checks++;
      if (seen !== 0) begin
         errors++;
         $display("FAIL abort_no_valid got %0d pulses want 0", seen);
      end
      rst_n = 1'b1;
      do_op(16'h0001, 16'h0001, 1'b0, 1'b1, s, c, lat, aw, ac, cins);
      checks++;
      if (aw !== 0) begin
         errors++;
         $display("FAIL abort_first_accept got wait %0d want 0", aw);
      end
      checks++;
      if ({c, s} !== 17'h00002) begin
         errors++;
         $display("FAIL abort_followup got %h want 00002", {c, s});
      end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] a, b, s;
      logic         cin, c;
      int           lat, aw, ac, prev;
      logic [7:0]   cins;
      logic [W:0]   exp;
      prev = -1;
      for (int k = 0; k < 24; k++) begin
         a   = (k % 6 == 0) ? {W{1'b1}} : W'($urandom);
         b   = (k % 4 == 1) ? {W{1'b1}} : W'($urandom);
         cin = 1'($urandom_range(0, 1));
         exp = ref_add(a, b, cin);
         do_op(a, b, cin, 1'b1, s, c, lat, aw, ac, cins);
         checks++;
         if ({c, s} !== exp || lat !== NIB) begin
            errors++;
            $display("FAIL b2b%0d_result got %h lat %0d want %h lat %0d", k, {c, s}, lat, exp, NIB);
         end
         if (prev >= 0) begin
            checks++;
            if (ac - prev !== NIB + 2) begin
               errors++;
               $display("FAIL b2b%0d_spacing got %0d want %0d", k, ac - prev, NIB + 2);
            end
         end
         prev = ac;
      end
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.op_a      = '0;
      bus.op_b      = '0;
      bus.op_cin    = 1'b0;
      bus.out_ready = 1'b0;
      test_reset();
      test_vectors();
      test_hold();
      test_reset_abort();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not complete");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
